// File: rtl/dmem_load_requester.sv
// Data-memory load issue stage: alignment/funct3 check, word read over req/ack, response to extractor.
// Latency: accept -> bus read next cycle -> response the cycle after ack (3 cycles min per load).
// Backpressure: one request outstanding; oReqReady is low outside IDLE, response held until iRspReady.
//
// Ports:
//   iCLK, iRST            clock, synchronous active-high reset
//   iReqValid/oReqReady   load request handshake; iAddr byte address, iFunct3 RV32I load type
//   oBusRead/oBusAddr     level-held word-aligned read request
//   iBusAck/iBusRData     single-cycle acknowledge with read data
//   oRspValid/iRspReady   response handshake; oRspData raw word, oRspAlignment addr[1:0],
//                         oRspFunct3, oRspMisaligned / oRspError status flags
//   oBusy                 high whenever the FSM is not idle
module dmem_load_requester #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iReqValid,
  output logic        oReqReady,
  input  logic [31:0] iAddr,
  input  logic [2:0]  iFunct3,
  output logic        oBusRead,
  output logic [31:0] oBusAddr,
  input  logic        iBusAck,
  input  logic [31:0] iBusRData,
  output logic        oRspValid,
  input  logic        iRspReady,
  output logic [31:0] oRspData,
  output logic [1:0]  oRspAlignment,
  output logic [2:0]  oRspFunct3,
  output logic        oRspMisaligned,
  output logic        oRspError,
  output logic        oBusy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_e;

  // Last counter value before giving up; the counter starts at 0 in the
  // first BUS cycle, so the read is held for exactly TIMEOUT_CYCLES cycles.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] data_q, data_d;
  logic        misal_q, misal_d;
  logic        err_q, err_d;
  logic [15:0] cnt_q, cnt_d;

  logic funct3_legal;
  logic addr_misaligned;

  // Request decode, evaluated on the incoming request in IDLE.
  always_comb begin
    funct3_legal = 1'b0;
    case (iFunct3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: funct3_legal = 1'b1;
      default:                                funct3_legal = 1'b0;
    endcase
  end

  // Word loads need both low bits clear; halfword loads (001/101) need bit 0 clear.
  always_comb begin
    addr_misaligned = 1'b0;
    if (iFunct3 == 3'b010) begin
      addr_misaligned = (iAddr[1:0] != 2'b00);
    end else if (iFunct3[1:0] == 2'b01) begin
      addr_misaligned = iAddr[0];
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    funct3_d = funct3_q;
    data_d   = data_q;
    misal_d  = misal_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (iReqValid) begin
          addr_d   = iAddr;
          funct3_d = iFunct3;
          data_d   = 32'd0;
          misal_d  = 1'b0;
          err_d    = 1'b0;
          cnt_d    = 16'd0;
          // Illegal funct3 outranks misalignment; faults skip the bus entirely.
          if (!funct3_legal) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (addr_misaligned) begin
            misal_d = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_BUS;
          end
        end
      end

      S_BUS: begin
        // Ack is checked first so an ack in the timeout cycle still delivers data.
        if (iBusAck) begin
          data_d  = iBusRData;
          misal_d = 1'b0;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          data_d  = 32'd0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      S_RESP: begin
        if (iRspReady) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      addr_q   <= 32'd0;
      funct3_q <= 3'd0;
      data_q   <= 32'd0;
      misal_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 16'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      funct3_q <= funct3_d;
      data_q   <= data_d;
      misal_q  <= misal_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Every output is either a register or a pure decode of the state register,
  // so neither iBusAck nor iRspReady reaches an output combinationally.
  assign oReqReady      = (state_q == S_IDLE);
  assign oBusRead       = (state_q == S_BUS);
  assign oRspValid      = (state_q == S_RESP);
  assign oBusy          = (state_q != S_IDLE);
  assign oBusAddr       = {addr_q[31:2], 2'b00};
  assign oRspData       = data_q;
  assign oRspAlignment  = addr_q[1:0];
  assign oRspFunct3     = funct3_q;
  assign oRspMisaligned = misal_q;
  assign oRspError      = err_q;

endmodule

// File: tb/tb_dmem_load_requester.sv
module tb_dmem_load_requester;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_vld_a, req_vld_b;
  logic [31:0] addr;
  logic [2:0]  f3;
  logic        bus_ack;
  logic [31:0] rdata;
  logic        rsp_rdy;

  logic        a_req_rdy, a_bus_rd, a_rsp_vld, a_mis, a_err, a_busy;
  logic [31:0] a_bus_addr, a_rsp_dat;
  logic [1:0]  a_align;
  logic [2:0]  a_f3;
  logic        b_req_rdy, b_bus_rd, b_rsp_vld, b_mis, b_err, b_busy;
  logic [31:0] b_bus_addr, b_rsp_dat;
  logic [1:0]  b_align;
  logic [2:0]  b_f3;

  // Status bundle: {req_ready, bus_read, rsp_valid, busy, misaligned, error}
  logic [5:0] a_st, b_st;
  assign a_st = {a_req_rdy, a_bus_rd, a_rsp_vld, a_busy, a_mis, a_err};
  assign b_st = {b_req_rdy, b_bus_rd, b_rsp_vld, b_busy, b_mis, b_err};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_load_requester dut_a (
    .iCLK(clk), .iRST(rst),
    .iReqValid(req_vld_a), .oReqReady(a_req_rdy),
    .iAddr(addr), .iFunct3(f3),
    .oBusRead(a_bus_rd), .oBusAddr(a_bus_addr),
    .iBusAck(bus_ack), .iBusRData(rdata),
    .oRspValid(a_rsp_vld), .iRspReady(rsp_rdy),
    .oRspData(a_rsp_dat), .oRspAlignment(a_align), .oRspFunct3(a_f3),
    .oRspMisaligned(a_mis), .oRspError(a_err), .oBusy(a_busy)
  );

  dmem_load_requester #(.TIMEOUT_CYCLES(4)) dut_b (
    .iCLK(clk), .iRST(rst),
    .iReqValid(req_vld_b), .oReqReady(b_req_rdy),
    .iAddr(addr), .iFunct3(f3),
    .oBusRead(b_bus_rd), .oBusAddr(b_bus_addr),
    .iBusAck(bus_ack), .iBusRData(rdata),
    .oRspValid(b_rsp_vld), .iRspReady(rsp_rdy),
    .oRspData(b_rsp_dat), .oRspAlignment(b_align), .oRspFunct3(b_f3),
    .oRspMisaligned(b_mis), .oRspError(b_err), .oBusy(b_busy)
  );

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (a_st !== 6'b100000) begin errors++; $display("FAIL reset_status_a got %b exp %b", a_st, 6'b100000); end
    checks++;
    if ({a_bus_addr, a_rsp_dat, a_align, a_f3} !== 69'd0) begin
      errors++; $display("FAIL reset_fields_a got %h %h %h %h exp all 0", a_bus_addr, a_rsp_dat, a_align, a_f3);
    end
    checks++;
    if (b_st !== 6'b100000) begin errors++; $display("FAIL reset_status_b got %b exp %b", b_st, 6'b100000); end
    rst = 1'b0;
    tick();
    checks++;
    if (a_st !== 6'b100000) begin errors++; $display("FAIL post_reset_idle got %b exp %b", a_st, 6'b100000); end
  endtask

  task automatic test_lw_fast;
    req_vld_a = 1'b1; addr = 32'h0000_1004; f3 = 3'b010;
    tick();                                  // edge 0: accepted
    req_vld_a = 1'b0; addr = 32'hFFFF_FFFF; f3 = 3'b111;
    checks++;
    if (a_st !== 6'b010100) begin errors++; $display("FAIL lw_cycle1_status got %b exp %b", a_st, 6'b010100); end
    checks++;
    if (a_bus_addr !== 32'h0000_1004) begin errors++; $display("FAIL lw_bus_addr got %h exp %h", a_bus_addr, 32'h0000_1004); end
    bus_ack = 1'b1; rdata = 32'hCAFE_BABE;
    tick();                                  // edge 1: ack taken
    bus_ack = 1'b0; rdata = 32'h0;
    checks++;
    if (a_st !== 6'b001100) begin errors++; $display("FAIL lw_cycle2_status got %b exp %b", a_st, 6'b001100); end
    checks++;
    if ({a_rsp_dat, a_align, a_f3} !== {32'hCAFE_BABE, 2'b00, 3'b010}) begin
      errors++; $display("FAIL lw_rsp got %h/%b/%b exp cafebabe/00/010", a_rsp_dat, a_align, a_f3);
    end
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
    checks++;
    if (a_st !== 6'b100000) begin errors++; $display("FAIL lw_back_idle got %b exp %b", a_st, 6'b100000); end
  endtask

  task automatic test_lbu_delayed;
    int high_cycles;
    high_cycles = 0;
    req_vld_a = 1'b1; addr = 32'h0000_2003; f3 = 3'b100;
    tick();
    req_vld_a = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (a_bus_rd === 1'b1 && a_bus_addr === 32'h0000_2000 && a_rsp_vld === 1'b0) high_cycles++;
      if (k == 5) begin bus_ack = 1'b1; rdata = 32'h1122_3344; end
      tick();
    end
    bus_ack = 1'b0; rdata = 32'h0;
    checks++;
    if (high_cycles !== 5) begin errors++; $display("FAIL lbu_read_held got %0d cycles exp 5", high_cycles); end
    checks++;
    if (a_st !== 6'b001100) begin errors++; $display("FAIL lbu_status got %b exp %b", a_st, 6'b001100); end
    checks++;
    if ({a_rsp_dat, a_align, a_f3} !== {32'h1122_3344, 2'b11, 3'b100}) begin
      errors++; $display("FAIL lbu_rsp got %h/%b/%b exp 11223344/11/100", a_rsp_dat, a_align, a_f3);
    end
    rsp_rdy = 1'b1;
    tick();
    rsp_rdy = 1'b0;
  endtask

  task automatic test_faults;
    // LH at odd address: misaligned in cycle 1, no bus access
    req_vld_a = 1'b1; addr = 32'h0000_0001; f3 = 3'b001;
    tick();
    req_vld_a = 1'b0;
    checks++;
    if (a_st !== 6'b001110) begin errors++; $display("FAIL lh_misal_status got %b exp %b", a_st, 6'b001110); end
    checks++;
    if ({a_rsp_dat, a_align} !== {32'h0, 2'b01}) begin
      errors++; $display("FAIL lh_misal_rsp got %h/%b exp 0/01", a_rsp_dat, a_align);
    end
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    // Reserved funct3 at an aligned address: error, no bus access
    req_vld_a = 1'b1; addr = 32'h0000_0100; f3 = 3'b011;
    tick();
    req_vld_a = 1'b0;
    checks++;
    if (a_st !== 6'b001101) begin errors++; $display("FAIL f3_illegal_status got %b exp %b", a_st, 6'b001101); end
    checks++;
    if ({a_rsp_dat, a_f3} !== {32'h0, 3'b011}) begin
      errors++; $display("FAIL f3_illegal_rsp got %h/%b exp 0/011", a_rsp_dat, a_f3);
    end
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    // Illegal funct3 at a misaligned address reports only the error
    req_vld_a = 1'b1; addr = 32'h0000_0003; f3 = 3'b110;
    tick();
    req_vld_a = 1'b0;
    checks++;
    if (a_st !== 6'b001101) begin errors++; $display("FAIL f3_priority_status got %b exp %b", a_st, 6'b001101); end
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    // LW at addr[1:0]=10 is misaligned
    req_vld_a = 1'b1; addr = 32'h0000_0006; f3 = 3'b010;
    tick();
    req_vld_a = 1'b0;
    checks++;
    if (a_st !== 6'b001110) begin errors++; $display("FAIL lw_misal_status got %b exp %b", a_st, 6'b001110); end
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    // LHU at addr[1:0]=10 is legal and reaches the bus
    req_vld_a = 1'b1; addr = 32'h0000_0006; f3 = 3'b101;
    tick();
    req_vld_a = 1'b0;
    checks++;
    if (a_st !== 6'b010100) begin errors++; $display("FAIL lhu_aligned_status got %b exp %b", a_st, 6'b010100); end
    bus_ack = 1'b1; rdata = 32'h0000_BEEF; tick(); bus_ack = 1'b0;
    checks++;
    if ({a_st, a_rsp_dat} !== {6'b001100, 32'h0000_BEEF}) begin
      errors++; $display("FAIL lhu_rsp got %b/%h exp 001100/0000beef", a_st, a_rsp_dat);
    end
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
  endtask

  task automatic test_timeout;
    int high_cycles;
    high_cycles = 0;
    req_vld_b = 1'b1; addr = 32'h0000_0040; f3 = 3'b010;
    tick();
    req_vld_b = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (b_bus_rd === 1'b1 && b_rsp_vld === 1'b0) high_cycles++;
      tick();
    end
    checks++;
    if (high_cycles !== 4) begin errors++; $display("FAIL timeout_read_held got %0d cycles exp 4", high_cycles); end
    checks++;
    if ({b_st, b_rsp_dat} !== {6'b001101, 32'h0}) begin
      errors++; $display("FAIL timeout_rsp got %b/%h exp 001101/00000000", b_st, b_rsp_dat);
    end
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    // Ack in the last allowed cycle wins over the timeout
    req_vld_b = 1'b1;
    tick();
    req_vld_b = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin bus_ack = 1'b1; rdata = 32'hA5A5_5A5A; end
      tick();
    end
    bus_ack = 1'b0; rdata = 32'h0;
    checks++;
    if ({b_st, b_rsp_dat} !== {6'b001100, 32'hA5A5_5A5A}) begin
      errors++; $display("FAIL timeout_ack_wins got %b/%h exp 001100/a5a55a5a", b_st, b_rsp_dat);
    end
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
    checks++;
    if (a_st !== 6'b100000) begin errors++; $display("FAIL idle_ignores_ack got %b exp %b", a_st, 6'b100000); end
  endtask

  task automatic test_back_to_back;
    int stable_cycles;
    stable_cycles = 0;
    req_vld_a = 1'b1; addr = 32'h0000_3000; f3 = 3'b010;
    tick();
    bus_ack = 1'b1; rdata = 32'h0BAD_F00D;
    addr = 32'h0000_4000;                    // next request waiting, must not be taken
    tick();
    bus_ack = 1'b0; rdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      if (a_st === 6'b001100 && a_rsp_dat === 32'h0BAD_F00D && a_align === 2'b00 && a_f3 === 3'b010)
        stable_cycles++;
      tick();
    end
    checks++;
    if (stable_cycles !== 3) begin errors++; $display("FAIL bp_stable got %0d cycles exp 3", stable_cycles); end
    rsp_rdy = 1'b1;
    tick();                                  // handshake edge
    rsp_rdy = 1'b0;
    checks++;
    if (a_st !== 6'b100000) begin errors++; $display("FAIL bp_after_handshake got %b exp %b", a_st, 6'b100000); end
    tick();                                  // waiting request taken now
    req_vld_a = 1'b0;
    checks++;
    if ({a_st, a_bus_addr} !== {6'b010100, 32'h0000_4000}) begin
      errors++; $display("FAIL bp_next_accept got %b/%h exp 010100/00004000", a_st, a_bus_addr);
    end
    bus_ack = 1'b1; rdata = 32'h1; tick(); bus_ack = 1'b0;
    rsp_rdy = 1'b1; tick(); rsp_rdy = 1'b0;
  endtask

  task automatic test_reset_mid;
    req_vld_a = 1'b1; addr = 32'h0000_5000; f3 = 3'b010;
    tick();
    req_vld_a = 1'b0;
    checks++;
    if (a_bus_rd !== 1'b1) begin errors++; $display("FAIL mid_in_bus got %b exp 1", a_bus_rd); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (a_st !== 6'b100000) begin errors++; $display("FAIL mid_reset_status got %b exp %b", a_st, 6'b100000); end
    bus_ack = 1'b1; rdata = 32'hDEAD_BEEF;   // late ack
    tick();
    bus_ack = 1'b0;
    tick();
    checks++;
    if ({a_st, a_rsp_dat} !== {6'b100000, 32'h0}) begin
      errors++; $display("FAIL late_ack_ignored got %b/%h exp 100000/00000000", a_st, a_rsp_dat);
    end
  endtask

  initial begin
    rst = 1'b1; req_vld_a = 1'b0; req_vld_b = 1'b0;
    addr = 32'h0; f3 = 3'b0; bus_ack = 1'b0; rdata = 32'h0; rsp_rdy = 1'b0;
    #1;
    test_reset();
    test_lw_fast();
    test_lbu_delayed();
    test_faults();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_load_requester.md
Name: dmem_load_requester

Overview:
- Issue stage for data-memory loads, directly upstream of the load byte/halfword extraction stage.
- Accepts a load request (byte address plus funct3) from the core over a valid/ready handshake.
- Checks alignment before any bus access, then performs a word-aligned read on the data bus with req/ack and a timeout.
- Delivers the raw 32-bit word, the byte offset (alignment) and funct3 to the extraction stage, with status flags, over a second valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 255, maximum number of cycles oBusRead stays high waiting for iBusAck; legal range 1..65535.

Ports:
- iCLK  in  1  clock; all state updates on the rising edge.
- iRST  in  1  synchronous reset, active-high.
- iReqValid  in  1  load request valid.
- oReqReady  out  1  request accepted this cycle when high together with iReqValid.
- iAddr  in  32  byte address of the load.
- iFunct3  in  3  RV32I load funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- oBusRead  out  1  bus read request, level-held until ack or timeout.
- oBusAddr  out  32  word-aligned bus address {addr[31:2],2'b00}.
- iBusAck  in  1  single-cycle read acknowledge; data valid in the same cycle.
- iBusRData  in  32  bus read data.
- oRspValid  out  1  response valid.
- iRspReady  in  1  consumer ready for the response.
- oRspData  out  32  raw word as read from the bus; 0 on any fault.
- oRspAlignment  out  2  latched iAddr[1:0].
- oRspFunct3  out  3  latched iFunct3.
- oRspMisaligned  out  1  misaligned access was detected; no bus access was made.
- oRspError  out  1  illegal funct3, or bus timeout.
- oBusy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (iRST high at the clock edge) applies the following:
  - State goes to IDLE.
  - All outputs are 0 except oReqReady, which is 1.
  - The timeout counter clears.
- Reset mid-transaction aborts the transaction: oBusRead drops at that edge and any in-flight ack is ignored.
- All outputs are registered or decoded from state only. There is no combinational path from iBusAck or iRspReady to any output.
- FSM states are IDLE, BUS and RESP.
- IDLE:
  - oReqReady=1. On iReqValid, latch iAddr, iFunct3 and iAddr[1:0].
  - Fault checks, in priority order:
    - funct3 not in {000,001,010,100,101} gives oRspError=1 and goes to RESP.
    - Otherwise, LW with addr[1:0]≠00, or LH/LHU with addr[0]=1, gives oRspMisaligned=1 and goes to RESP.
  - In both fault cases oRspData=0 and oBusRead is never asserted.
  - Otherwise go to BUS: oBusRead=1 and oBusAddr driven from the next cycle, counter=0.
- BUS:
  - oReqReady=0. oBusRead and oBusAddr are held stable.
  - The counter increments each cycle without an ack.
  - On iBusAck: capture iBusRData into oRspData, set flags to 0, drop oBusRead and go to RESP.
  - When the counter reaches TIMEOUT_CYCLES-1 with no ack: drop oBusRead, oRspData=0, oRspError=1, go to RESP.
  - If iBusAck arrives in the same cycle as the timeout, the ack wins: data is captured and there is no error.
- RESP:
  - oRspValid=1. All oRsp* outputs are held stable until iRspReady.
  - On iRspValid·iRspReady: oRspValid drops and the state returns to IDLE.
  - oReqReady stays 0 in RESP, so there is at most one outstanding request.
- iBusAck seen in IDLE or RESP is ignored.
- Latency with ack in the first BUS cycle:
  - Request accepted at edge 0.
  - oBusRead high in cycle 1.
  - Ack in cycle 1.
  - oRspValid high in cycle 2.
  - Throughput is at most one load per 3 cycles.
- Timeout response: oRspValid rises TIMEOUT_CYCLES+1 cycles after acceptance.
- The flags are mutually exclusive. They clear when the next request is accepted.

Test Plan:
- LW at 0x0000_1004, ack in the first BUS cycle with 0xCAFE_BABE → oBusAddr=0x0000_1004; oRspValid in cycle 2 with data 0xCAFE_BABE, alignment 00, funct3 010, both flags 0.
- LBU at 0x0000_2003, ack delayed 5 cycles with 0x1122_3344 → oBusAddr=0x0000_2000; oBusRead held for exactly 5 cycles; response data 0x1122_3344, alignment 11.
- LH at 0x0000_0001 → oBusRead never asserts; oRspMisaligned=1, oRspData=0 in cycle 1. Funct3=011 at an aligned address → oRspError=1, no bus access.
- TIMEOUT_CYCLES=4, no ack → oBusRead high for 4 cycles, then oRspError=1 and data 0. A second run with ack in the 4th cycle → data captured, no error.
- iRspReady held low for 3 cycles → response fields stable and oReqReady=0 throughout. A new iReqValid is not accepted until the cycle after the handshake.
- iRST high while in BUS → at the next edge oBusRead=0, oBusy=0, oReqReady=1. A late iBusAck afterwards produces no response.
